// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, address field positions and FSM encoding for the data cache
package dcache_pkg;

  localparam int BLOCK_W    = 128;
  localparam int WORD_W     = 32;
  localparam int MEM_ADDR_W = 28;

  // byte address layout: [31:INDEX_LSB+INDEX_W] tag, [INDEX_LSB +: INDEX_W] index, [3:2] word offset
  localparam int OFFSET_LSB = 2;
  localparam int OFFSET_W   = 2;
  localparam int INDEX_LSB  = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_FILL      = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - valid/dirty/tag/data storage with async read, word write and line fill
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = 3,
  parameter int TAG_W     = 25
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [INDEX_W-1:0]  index,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_data,
  input  logic                wr_en,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [WORD_W-1:0]   wr_word,
  input  logic                fill_en,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];
  logic [BLOCK_W-1:0]   data_d [NUM_LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  // a fill makes the line valid and clean; a store hit only marks it dirty
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_en) begin
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
    end else if (wr_en) begin
      dirty_d[index] = 1'b1;
    end
  end

  // fill replaces tag and whole line; a store hit merges one word
  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    if (fill_en) begin
      tag_d[index]  = fill_tag;
      data_d[index] = fill_data;
    end else if (wr_en) begin
      data_d[index][{wr_offset, 5'b00000} +: WORD_W] = wr_word;
    end
  end

  // status bits clear asynchronously so every line is invalid right out of reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // tag and data contents are meaningless until a fill, so they carry no reset
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache controller
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = 3,
  parameter int TAG_W     = 25
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [31:0]   cpu_address,
  input  logic [31:0]   cpu_writedata,
  output logic [31:0]   cpu_readdata,
  output logic          cpu_busywait,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_address,
  output logic [127:0]  mem_writedata,
  input  logic [127:0]  mem_readdata,
  input  logic          mem_busywait
);

  state_e state_q, state_d;

  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    cpu_tag;
  logic [OFFSET_W-1:0] offset;
  logic                request;
  logic                hit;
  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                wr_en;
  logic                fill_en;
  logic                unused_byte_offset;

  assign index              = cpu_address[INDEX_LSB +: INDEX_W];
  assign cpu_tag            = cpu_address[31 -: TAG_W];
  assign offset             = cpu_address[OFFSET_LSB +: OFFSET_W];
  assign request            = cpu_read | cpu_write;
  assign hit                = line_valid && (line_tag == cpu_tag);
  assign unused_byte_offset = ^cpu_address[1:0];

  assign cpu_readdata  = line_data[{offset, 5'b00000} +: WORD_W];
  assign mem_writedata = line_data;

  dcache_line_array #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clock     (clock),
    .reset     (reset),
    .index     (index),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (wr_en),
    .wr_offset (offset),
    .wr_word   (cpu_writedata),
    .fill_en   (fill_en),
    .fill_tag  (cpu_tag),
    .fill_data (mem_readdata)
  );

  // state register; reset abandons any memory transfer in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and outputs; memory strobes depend on state alone so they drop one cycle after the last beat
  always_comb begin
    state_d      = state_q;
    cpu_busywait = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = cpu_address[31:4];
    wr_en        = 1'b0;
    fill_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (request && !reset) begin
          if (hit) begin
            // a simultaneous read and write is treated as a write
            wr_en = cpu_write;
          end else begin
            cpu_busywait = 1'b1;
            state_d      = (line_valid && line_dirty) ? ST_WRITEBACK : ST_FETCH;
          end
        end
      end
      ST_WRITEBACK: begin
        cpu_busywait = 1'b1;
        mem_write    = 1'b1;
        mem_address  = {line_tag, index};
        if (!mem_busywait) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        cpu_busywait = 1'b1;
        mem_read     = 1'b1;
        if (!mem_busywait) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        // the last beat lands on the edge that leaves FETCH, so the line is captured one cycle later
        cpu_busywait = 1'b1;
        fill_en      = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed scoreboard bench for dcache_controller against a 16-beat block memory
module tb_dcache_controller;

  logic         clock;
  logic         reset;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_address;
  logic [31:0]  cpu_writedata;
  logic [31:0]  cpu_readdata;
  logic         cpu_busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];

  logic [127:0] mem_model [64];
  logic [3:0]   beat_cnt;

  int           rd_beats = 0;
  int           wr_beats = 0;
  int           both_high = 0;
  logic [27:0]  last_rd_addr = '0;
  logic [27:0]  last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;

  dcache_controller dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .cpu_busywait  (cpu_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] init_block(input int b);
    logic [7:0] bb;
    bb = 8'(b);
    if (b == 4) return 128'h33334444_11112222_CAFEF00D_DEADBEEF;
    return {bb, bb, bb, 8'h03, bb, bb, bb, 8'h02, bb, bb, bb, 8'h01, bb, bb, bb, 8'h00};
  endfunction

  // block memory: busy until the 16th cycle of a request, transfer completes on that edge
  assign mem_busywait = (mem_read || mem_write) && (beat_cnt != 4'd15);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_cnt     <= '0;
      mem_readdata <= '0;
      for (int i = 0; i < 64; i++) mem_model[i] <= init_block(i);
    end else if (mem_read || mem_write) begin
      if (beat_cnt == 4'd15) begin
        beat_cnt <= '0;
        if (mem_write) mem_model[mem_address[5:0]] <= mem_writedata;
        else           mem_readdata <= mem_model[mem_address[5:0]];
      end else begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end else begin
      beat_cnt <= '0;
    end
  end

  always @(negedge clock) begin
    if (mem_read) begin
      rd_beats++;
      last_rd_addr = mem_address;
    end
    if (mem_write) begin
      wr_beats++;
      last_wr_addr = mem_address;
      last_wr_data = mem_writedata;
    end
    if (mem_read && mem_write) both_high++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic is_wr, input logic [31:0] addr, input logic [31:0] data,
                        input int exp_cycles, input logic [27:0] exp_rd_addr,
                        input logic [27:0] exp_wr_addr);
    int cycles;
    int rd0;
    int wr0;
    logic [31:0] exp_word;
    string name;
    name = $sformatf("%s_%08h", is_wr ? "wr" : "rd", addr);
    @(negedge clock);
    cpu_address   = addr;
    cpu_writedata = data;
    cpu_read      = !is_wr;
    cpu_write     = is_wr;
    if (!is_wr) sb_q.push_back(data);
    #1;
    rd0 = rd_beats;
    wr0 = wr_beats;
    check({name, "_busy_at_request"}, 128'(cpu_busywait), 128'(exp_cycles != 0));
    cycles = 0;
    while (cpu_busywait && cycles < 200) begin
      @(negedge clock);
      #1;
      cycles++;
    end
    check({name, "_stall_cycles"}, 128'(cycles), 128'(exp_cycles));
    check({name, "_fetch_beats"}, 128'(rd_beats - rd0), 128'((exp_cycles != 0) ? 16 : 0));
    check({name, "_wb_beats"}, 128'(wr_beats - wr0), 128'((exp_cycles == 34) ? 16 : 0));
    if (exp_cycles != 0) check({name, "_fetch_addr"}, 128'(last_rd_addr), 128'(exp_rd_addr));
    if (exp_cycles == 34) check({name, "_wb_addr"}, 128'(last_wr_addr), 128'(exp_wr_addr));
    if (!is_wr) begin
      exp_word = sb_q.pop_front();
      check({name, "_readdata"}, 128'(cpu_readdata), 128'(exp_word));
    end
    @(posedge clock);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    cpu_read      = 1'b0;
    cpu_write     = 1'b0;
    cpu_address   = '0;
    cpu_writedata = '0;
    repeat (3) @(negedge clock);
    check("reset_busywait", 128'(cpu_busywait), 128'(0));
    check("reset_mem_read", 128'(mem_read), 128'(0));
    check("reset_mem_write", 128'(mem_write), 128'(0));
    reset = 1'b0;

    // cold read miss, then hits on the same line
    access(1'b0, 32'h0000_0040, 32'hDEADBEEF, 18, 28'h000_0004, 28'h0);
    access(1'b0, 32'h0000_0044, 32'hCAFEF00D, 0, 28'h0, 28'h0);
    access(1'b1, 32'h0000_0048, 32'h12345678, 0, 28'h0, 28'h0);
    access(1'b0, 32'h0000_0048, 32'h12345678, 0, 28'h0, 28'h0);

    // conflicting tag on index 4 forces write-back of the dirty line
    access(1'b0, 32'h0000_00C0, 32'h0C0C0C00, 34, 28'h000_000C, 28'h000_0004);
    check("wb_data_word2", 128'(last_wr_data[95:64]), 128'h12345678);
    check("mem_block_004", mem_model[4], 128'h33334444_12345678_CAFEF00D_DEADBEEF);

    // cold write miss allocates, completes the store and leaves the line dirty
    access(1'b1, 32'h0000_0100, 32'hA5A5A5A5, 18, 28'h000_0010, 28'h0);
    access(1'b0, 32'h0000_0100, 32'hA5A5A5A5, 0, 28'h0, 28'h0);
    access(1'b0, 32'h0000_0200, 32'h20202000, 34, 28'h000_0020, 28'h000_0010);
    check("wb_data_word0", 128'(last_wr_data[31:0]), 128'hA5A5A5A5);
    check("mem_block_010", mem_model[16], {init_block(16)[127:32], 32'hA5A5A5A5});

    // reset in the 5th FETCH cycle aborts the fill and invalidates the array
    @(negedge clock);
    cpu_address = 32'h0000_0040;
    cpu_read    = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    check("fetch_before_reset", 128'(mem_read), 128'(1));
    reset = 1'b1;
    #1;
    check("reset_drops_mem_read", 128'(mem_read), 128'(0));
    check("reset_drops_mem_write", 128'(mem_write), 128'(0));
    check("reset_drops_busywait", 128'(cpu_busywait), 128'(0));
    @(negedge clock);
    cpu_read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    access(1'b0, 32'h0000_00C0, 32'h0C0C0C00, 18, 28'h000_000C, 28'h0);
    access(1'b0, 32'h0000_0040, 32'hDEADBEEF, 18, 28'h000_0004, 28'h0);

    check("never_read_and_write", 128'(both_high), 128'(0));
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache that sits between the core's load/store unit and the block-wide data memory.
- Acts as the initiator of the 128-bit block memory protocol:
  - drives mem_read or mem_write plus the block address;
  - holds the request until the memory drops mem_busywait;
  - fills or evicts a whole 16-byte line per transaction.
- Presents a 32-bit word interface with a busywait stall to the core.

Parameters:
- NUM_LINES, 8, number of cache lines (power of two).
- INDEX_W, 3, log2(NUM_LINES).
- TAG_W, 25, address bits above index and offset (32-4-INDEX_W).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_read  in  1  word load request, held until cpu_busywait low.
- cpu_write  in  1  word store request, held until cpu_busywait low.
- cpu_address  in  32  byte address; bits [1:0] ignored.
- cpu_writedata  in  32  store data.
- cpu_readdata  out  32  load data, valid while cpu_read and cpu_busywait low.
- cpu_busywait  out  1  stall to core.
- mem_read  out  1  block fetch request.
- mem_write  out  1  block write-back request.
- mem_address  out  28  block address (byte address [31:4]).
- mem_writedata  out  128  evicted line, byte 0 in [7:0].
- mem_readdata  in  128  fetched line, byte 0 in [7:0].
- mem_busywait  in  1  memory busy; low in the final cycle of a transfer.

Behaviour:
- Address split:
  - tag = [31:7]
  - index = [6:4]
  - word offset = [3:2]
  - word w occupies line bits [32w+31:32w].
- Per line storage: valid, dirty, tag, 128-bit data. Reset clears all valid and dirty bits; data and tag are don't-care.
- Reset outputs:
  - mem_read = 0, mem_write = 0, cpu_busywait = 0
  - cpu_readdata = line word (don't-care)
  - state = IDLE
- hit = valid[index] and tag match. It is combinational from cpu_address.
- State machine:
  - IDLE:
    - Read hit: cpu_readdata is driven combinationally from the selected word; cpu_busywait = 0 in the same cycle (zero-wait).
    - Write hit: cpu_busywait = 0; at the next edge the word is written and dirty is set.
    - Miss with victim not (valid and dirty): cpu_busywait = 1 combinationally; next state FETCH.
    - Miss with a dirty victim: cpu_busywait = 1; next state WRITEBACK.
  - WRITEBACK:
    - mem_write = 1, mem_address = {victim tag, index}, mem_writedata = victim line.
    - Hold until mem_busywait is sampled 0 at an edge, then go to FETCH.
  - FETCH:
    - mem_read = 1, mem_address = cpu_address[31:4].
    - Hold until mem_busywait is sampled 0 at an edge, then go to FILL.
  - FILL:
    - mem_read = 0. At the edge, capture mem_readdata into the line; set valid = 1, dirty = 0, tag = new tag.
    - Next state IDLE, where the access replays as a hit.
- mem_read and mem_write are decoded from state only, never both high. They drop in the cycle after mem_busywait is seen low, so the memory's internal beat counter wraps cleanly.
- mem_readdata's final byte becomes valid at the same edge that ends FETCH. The line is therefore captured in FILL, never at the FETCH exit edge.
- cpu_busywait = 1 in WRITEBACK, FETCH and FILL, and in IDLE on a miss with a request present.
- Request timing:
  - No request: cpu_busywait = 0, and no memory activity occurs.
  - Core must hold address, data and request stable while stalled; changes mid-miss are undefined.
  - cpu_read and cpu_write both high is illegal; the block treats it as a write.
- Miss latency with the 16-beat memory:
  - clean miss: 16 FETCH cycles + 1 FILL + 1 IDLE hit cycle;
  - dirty miss: adds 16 WRITEBACK cycles.
- Reset asserted mid-transaction:
  - immediately returns to IDLE;
  - mem_read and mem_write drop asynchronously;
  - all lines are invalidated;
  - the interrupted write-back is lost.

Decomposition:
- Shared package dcache_pkg holds:
  - state encoding (IDLE, WRITEBACK, FETCH, FILL);
  - BLOCK_W = 128, WORD_W = 32, MEM_ADDR_W = 28;
  - offset and index bit positions.
- One natural sub-module: dcache_line_array. It holds valid, dirty, tag and data storage, with asynchronous read, a synchronous word write, a full-line fill port and asynchronous clear on reset.
- The controller FSM stays in dcache_controller.

Test Plan:
- Reset, then cpu_read 0x00000040 with the memory block at 0x004 preloaded so word0 = 0xDEADBEEF:
  - cpu_busywait rises combinationally;
  - mem_read is high for 16 cycles with mem_address = 0x0000004;
  - FILL follows, then cpu_readdata = 0xDEADBEEF.
- Repeat read of 0x00000044 immediately: hit; cpu_busywait stays 0; mem_read never rises; data = word1 of the same block.
- cpu_write 0x00000048 with 0x12345678: zero-wait hit; the following read of 0x00000048 returns 0x12345678; the line is dirty.
- cpu_read 0x000000C0 (same index 4, new tag):
  - mem_write for 16 cycles with mem_address = 0x0000004, containing 0x12345678 in bits [95:64];
  - then mem_read from 0x000000C;
  - memory block 0x004 later reads back the stored value.
- Cold write miss to 0x00000100 with 0xA5A5A5A5: fetch without write-back; after FILL the store completes and the line is dirty.
- Assert reset on the 5th cycle of FETCH:
  - mem_read drops the same cycle and cpu_busywait goes to 0;
  - the subsequent read of 0x00000040 misses again (line invalidated).
